// File: rtl/text_mode_pkg.sv
// Shared text-mode constants, control codes and write-sequencer state.
// The framebuffer read side imports the same geometry constants.
package text_mode_pkg;

  localparam int TEXT_COLS   = 80;
  localparam int TEXT_ROWS   = 30;
  localparam int TEXT_ADDR_W = 12;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_ESC   = 8'h1B;
  localparam logic [7:0] CHR_BLANK = 8'h20;

  localparam logic [6:0] LAST_COL = 7'(TEXT_COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(TEXT_ROWS - 1);
  localparam logic [TEXT_ADDR_W-1:0] LAST_ADDR =
    TEXT_ADDR_W'(TEXT_COLS * TEXT_ROWS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ESC_ROW,
    ST_ESC_COL
  } state_t;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Terminal cursor: column/row registers with wrap-only motion
// and the linear text RAM address of the current cell.
module text_cursor
  import text_mode_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   home,
  input  logic                   load,
  input  logic                   advance,
  input  logic                   newline,
  input  logic                   carriage,
  input  logic                   backspace,
  input  logic [4:0]             load_row,
  input  logic [6:0]             load_col,
  output logic [6:0]             col,
  output logic [4:0]             row,
  output logic [TEXT_ADDR_W-1:0] addr
);

  logic [4:0]             next_row;
  logic [TEXT_ADDR_W-1:0] row_w;

  assign next_row = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  assign row_w    = TEXT_ADDR_W'(row);
  // row*80 as shifts; at most 2399, fits the address width
  assign addr = (row_w << 6) + (row_w << 4) + TEXT_ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      unique case (1'b1)
        home: begin
          col <= '0;
          row <= '0;
        end
        load: begin
          col <= load_col;
          row <= load_row;
        end
        advance: begin
          if (col == LAST_COL) begin
            col <= '0;
            row <= next_row;
          end else begin
            col <= col + 7'd1;
          end
        end
        newline:  row <= next_row;
        carriage: col <= '0;
        backspace: begin
          if (col != 7'd0) col <= col - 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// Terminal-style write sequencer owning the text RAM write port:
// control-code decode, escape cursor positioning and full-screen clear.
module text_write_ctrl
  import text_mode_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [TEXT_ADDR_W-1:0] wr_addr,
  output logic [7:0]             wr_data,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   overrun,
  output logic [6:0]             cursor_col,
  output logic [4:0]             cursor_row
);

  state_t                 state;
  logic [TEXT_ADDR_W-1:0] clr_addr;
  logic [7:0]             esc_row;
  logic [TEXT_ADDR_W-1:0] cur_addr;
  logic                   idle_rx;
  logic                   clr_done;
  logic                   cur_load;

  assign busy     = rst | (state == ST_CLEAR);
  assign idle_rx  = (state == ST_IDLE) & rx_valid;
  assign clr_done = (state == ST_CLEAR) & (clr_addr == LAST_ADDR);
  assign cur_load = (state == ST_ESC_COL) & rx_valid
                  & (esc_row < 8'(TEXT_ROWS))
                  & (rx_byte < 8'(TEXT_COLS));

  text_cursor u_cursor (
    .clk       (clk),
    .rst       (rst),
    .home      (clr_done),
    .load      (cur_load),
    .advance   (idle_rx & is_print(rx_byte)),
    .newline   (idle_rx & (rx_byte == CHR_LF)),
    .carriage  (idle_rx & (rx_byte == CHR_CR)),
    .backspace (idle_rx & (rx_byte == CHR_BS)),
    .load_row  (esc_row[4:0]),
    .load_col  (rx_byte[6:0]),
    .col       (cursor_col),
    .row       (cursor_row),
    .addr      (cur_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= CHR_BLANK;
      overrun  <= 1'b0;
      esc_row  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (rx_valid && state == ST_CLEAR) overrun <= 1'b1;
      unique case (state)
        ST_CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_addr;
          wr_data <= CHR_BLANK;
          if (clr_addr == LAST_ADDR) state <= ST_IDLE;
          else clr_addr <= clr_addr + 1'b1;
        end
        ST_IDLE: begin
          if (rx_valid) begin
            if (is_print(rx_byte)) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= rx_byte;
            end else if (rx_byte == CHR_BS) begin
              if (cursor_col != 7'd0) begin
                wr_en   <= 1'b1;
                wr_addr <= cur_addr - 1'b1;
                wr_data <= CHR_BLANK;
              end
            end else if (rx_byte == CHR_FF) begin
              state    <= ST_CLEAR;
              clr_addr <= '0;
            end else if (rx_byte == CHR_ESC) begin
              state <= ST_ESC_ROW;
            end
          end
        end
        ST_ESC_ROW: begin
          if (rx_valid) begin
            esc_row <= rx_byte;
            state   <= ST_ESC_COL;
          end
        end
        ST_ESC_COL: begin
          if (rx_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: linear-cell screen model plus directed
// terminal sequences with hand-computed expectations.
module tb_text_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        overrun;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int checks = 0;
  int failures = 0;
  int wcount = 0;

  always #10 clk = ~clk;

  text_write_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .overrun    (overrun),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Screen model: cursor as a linear cell index, clear as a countdown
  bit started = 0;
  bit m_clearing;
  int m_cnt, m_col, m_row, m_esc, m_erow;
  bit m_wen, m_ovr;
  int m_waddr, m_wdata;

  always @(posedge clk) begin
    if (rst) begin
      started = 1; m_clearing = 1; m_cnt = 0; m_wen = 0;
      m_waddr = 0; m_wdata = 32; m_col = 0; m_row = 0;
      m_ovr = 0; m_esc = 0; m_erow = 0;
    end else if (started) begin
      m_wen = 0;
      if (m_clearing) begin
        if (rx_valid) m_ovr = 1;
        m_wen = 1; m_waddr = m_cnt; m_wdata = 32; m_cnt++;
        if (m_cnt == 2400) begin
          m_clearing = 0; m_col = 0; m_row = 0;
        end
      end else if (rx_valid) begin
        int b, lin;
        b = int'(rx_byte);
        if (m_esc == 1) begin
          m_erow = b; m_esc = 2;
        end else if (m_esc == 2) begin
          if (m_erow < 30 && b < 80) begin
            m_row = m_erow; m_col = b;
          end
          m_esc = 0;
        end else if (b >= 32 && b <= 126) begin
          lin = m_row * 80 + m_col;
          m_wen = 1; m_waddr = lin; m_wdata = b;
          lin = (lin + 1) % 2400;
          m_row = lin / 80; m_col = lin % 80;
        end else if (b == 13) m_col = 0;
        else if (b == 10) m_row = (m_row + 1) % 30;
        else if (b == 8) begin
          if (m_col > 0) begin
            m_col--; m_wen = 1;
            m_waddr = m_row * 80 + m_col; m_wdata = 32;
          end
        end else if (b == 12) begin
          m_clearing = 1; m_cnt = 0;
        end else if (b == 27) m_esc = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (wr_en === 1'b1) wcount++;
    if (started) begin
      chk("wr_en", int'(wr_en), int'(m_wen));
      if (m_wen) begin
        chk("wr_addr", int'(wr_addr), m_waddr);
        chk("wr_data", int'(wr_data), m_wdata);
      end
      chk("busy", int'(busy), int'(rst || m_clearing));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("cursor_col", int'(cursor_col), m_col);
      chk("cursor_row", int'(cursor_row), m_row);
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) done = 1;
    end
    chk(name, int'(done), 1);
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", int'(busy), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 8'h20);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: power-up clear
    wait_idle("init_clear_timeout");
    chk("init_writes", wcount, 2400);
    chk("init_last_addr", int'(wr_addr), 2399);
    chk("init_col", int'(cursor_col), 0);
    chk("init_row", int'(cursor_row), 0);

    // 2: two characters
    send(8'h41);
    chk("A_en", int'(wr_en), 1);
    chk("A_addr", int'(wr_addr), 0);
    chk("A_data", int'(wr_data), 8'h41);
    send(8'h42);
    chk("B_addr", int'(wr_addr), 1);
    chk("B_data", int'(wr_data), 8'h42);
    chk("B_col", int'(cursor_col), 2);

    // 3: last cell then wrap
    send(8'h1B); send(8'd29); send(8'd79);
    send(8'h5A);
    chk("Z_addr", int'(wr_addr), 2399);
    chk("Z_data", int'(wr_data), 8'h5A);
    chk("Z_col", int'(cursor_col), 0);
    chk("Z_row", int'(cursor_row), 0);

    // 4: rejected escape, CR, LF
    send(8'h1B); send(8'd3); send(8'd10);
    base = wcount;
    send(8'h1B); send(8'd30); send(8'd5);
    chk("esc_bad_row", int'(cursor_row), 3);
    chk("esc_bad_col", int'(cursor_col), 10);
    send(8'h0D); send(8'h0A);
    chk("crlf_row", int'(cursor_row), 4);
    chk("crlf_col", int'(cursor_col), 0);
    chk("crlf_nowrite", wcount - base, 0);

    // 5: backspace at col 0 and mid-row
    send(8'h08);
    chk("bs0_nowrite", wcount - base, 0);
    send(8'h1B); send(8'd2); send(8'd5);
    send(8'h08);
    chk("bs_addr", int'(wr_addr), 164);
    chk("bs_data", int'(wr_data), 8'h20);
    chk("bs_col", int'(cursor_col), 4);

    // ignored code, back-to-back bytes, LF wrap at last row
    base = wcount;
    send(8'h01);
    chk("ign_nowrite", wcount - base, 0);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = 8'h78;
    @(posedge clk); #1;
    rx_byte = 8'h79;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b_writes", wcount - base, 2);
    chk("b2b_addr", int'(wr_addr), 165);
    chk("b2b_col", int'(cursor_col), 6);
    send(8'h1B); send(8'd29); send(8'd0);
    send(8'h0A);
    chk("lf_wrap_row", int'(cursor_row), 0);

    // 6: form feed with a byte arriving mid-clear
    send(8'h0C);
    chk("ff_busy", int'(busy), 1);
    base = wcount;
    repeat (100) @(posedge clk);
    #1; rx_valid = 1'b1; rx_byte = 8'h51;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk); #1;
    chk("ovr_set", int'(overrun), 1);
    wait_idle("ff_clear_timeout");
    chk("ff_writes", wcount - base, 2400);
    chk("ff_col", int'(cursor_col), 0);
    chk("ff_row", int'(cursor_row), 0);
    send(8'h43);
    chk("post_ff_addr", int'(wr_addr), 0);
    chk("ovr_sticky", int'(overrun), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
